// File: rtl/fetch_row_packer.sv
// Packs ROW_BEATS input beats into one buffer row and writes it at consecutive
// wrapping addresses, for a programmable number of rows per load.

module fetch_row_packer_slot #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end
endmodule

module fetch_row_packer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int BEAT_PIX    = 16,
  parameter int ROW_BEATS   = 6,
  parameter int DEPTH       = 96
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [6:0]                            base_addr_i,
  input  logic [6:0]                            row_num_i,
  input  logic                                  in_valid_i,
  input  logic [BEAT_PIX*PIXEL_WIDTH-1:0]       in_data_i,
  output logic                                  in_ready_o,
  output logic                                  wrif_en_o,
  output logic [6:0]                            wrif_addr_o,
  output logic [BEAT_PIX*ROW_BEATS*PIXEL_WIDTH-1:0] wrif_data_o,
  output logic                                  busy_o,
  output logic                                  done_o
);
  localparam int BEAT_W = BEAT_PIX * PIXEL_WIDTH;
  localparam int BW     = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(ROW_BEATS - 1);
  localparam logic [6:0]    DEPTH_A   = 7'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] beat_cnt;
  logic [6:0]    rows_done, row_cnt, cur_addr;
  logic          beat_acc;

  logic [ROW_BEATS-1:0][BEAT_W-1:0] slot_q;
  logic [ROW_BEATS-1:0][BEAT_W-1:0] row_asm;

  assign beat_acc   = (state == FILL) && in_valid_i;
  assign in_ready_o = (state == FILL);
  assign wrif_en_o  = (state == WRITE);
  assign busy_o     = (state == FILL) || (state == WRITE);
  assign done_o     = (state == DONE);

  // Beat k lands in row slot ROW_BEATS-1-k so the first beat ends up in the MSBs;
  // the final beat bypasses its slot and goes straight into the write register.
  genvar k;
  generate
    for (k = 0; k < ROW_BEATS; k++) begin : g_slot
      if (k < ROW_BEATS - 1) begin : g_reg
        fetch_row_packer_slot #(.W(BEAT_W)) u_slot (
          .clk (clk),
          .rst (rst),
          .ld  (beat_acc && (beat_cnt == BW'(k))),
          .d   (in_data_i),
          .q   (slot_q[k])
        );
        assign row_asm[ROW_BEATS-1-k] = slot_q[k];
      end else begin : g_byp
        assign slot_q[k]  = in_data_i;
        assign row_asm[0] = in_data_i;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      rows_done   <= '0;
      row_cnt     <= '0;
      cur_addr    <= '0;
      wrif_addr_o <= '0;
      wrif_data_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          row_cnt   <= (row_num_i > DEPTH_A) ? DEPTH_A : row_num_i;
          cur_addr  <= base_addr_i % DEPTH_A;
          rows_done <= '0;
          beat_cnt  <= '0;
          state     <= (row_num_i == 7'd0) ? DONE : FILL;
        end
        FILL: if (in_valid_i) begin
          if (beat_cnt == LAST_BEAT) begin
            wrif_data_o <= row_asm;
            wrif_addr_o <= cur_addr;
            beat_cnt    <= '0;
            state       <= WRITE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        WRITE: begin
          rows_done <= rows_done + 7'd1;
          cur_addr  <= (cur_addr == DEPTH_A - 7'd1) ? 7'd0 : cur_addr + 7'd1;
          state     <= (rows_done + 7'd1 == row_cnt) ? DONE : FILL;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_row_packer.sv
// Directed bench for fetch_row_packer: one task per scenario, inline checks.

module tb_fetch_row_packer;
  localparam int PW = 8, BP = 16, RB = 6, DEPTH = 96;
  localparam int BEAT_W = PW * BP;
  localparam int ROW_W  = BEAT_W * RB;

  logic              clk = 0;
  logic              rst = 0;
  logic              start_i = 0;
  logic [6:0]        base_addr_i = 0, row_num_i = 0;
  logic              in_valid_i = 0;
  logic [BEAT_W-1:0] in_data_i = '0;
  logic              in_ready_o, wrif_en_o, busy_o, done_o;
  logic [6:0]        wrif_addr_o;
  logic [ROW_W-1:0]  wrif_data_o;

  int checks = 0, failures = 0;
  int done_cnt = 0;
  bit ready_seen = 0;
  logic [6:0]       wq_addr[$];
  logic [ROW_W-1:0] wq_data[$];

  fetch_row_packer #(.PIXEL_WIDTH(PW), .BEAT_PIX(BP), .ROW_BEATS(RB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .row_num_i(row_num_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .wrif_en_o(wrif_en_o), .wrif_addr_o(wrif_addr_o),
    .wrif_data_o(wrif_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wrif_en_o) begin
      wq_addr.push_back(wrif_addr_o);
      wq_data.push_back(wrif_data_o);
    end
    if (done_o) done_cnt++;
    if (in_ready_o) ready_seen = 1;
  end

  function automatic logic [BEAT_W-1:0] beat(int v);
    logic [BEAT_W-1:0] b;
    for (int p = 0; p < BP; p++) b[p*PW +: PW] = 8'((v * 16 + p) & 255);
    return b;
  endfunction

  function automatic logic [ROW_W-1:0] row_exp(int first);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int j = 0; j < RB; j++) r = (r << BEAT_W) | ROW_W'(beat(first + j));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    done_cnt   = 0;
    ready_seen = 0;
  endtask

  task automatic do_start(input int base, input int rows);
    base_addr_i = 7'(base);
    row_num_i   = 7'(rows);
    start_i     = 1;
    step();
    start_i     = 0;
  endtask

  task automatic send_beats(input int first, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int t;
      if (gaps) begin
        in_valid_i = 0;
        repeat ($urandom_range(0, 3)) step();
      end
      in_data_i  = beat(first + i);
      in_valid_i = 1;
      acc = 0;
      t   = 0;
      while (!acc && t < 50) begin
        acc = in_ready_o;
        step();
        t++;
      end
      if (!acc) begin
        checks++; failures++;
        $display("FAIL beat_accept beat=%0d not accepted within 50 cycles", first + i);
      end
    end
    in_valid_i = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == d0) begin
      checks++; failures++;
      $display("FAIL done_timeout no done_o within %0d cycles", budget);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    rst = 0;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL rst_in_ready actual=%b expected=0", in_ready_o); end
    checks++; if (wrif_en_o !== 1'b0) begin failures++; $display("FAIL rst_wrif_en actual=%b expected=0", wrif_en_o); end
    checks++; if (wrif_addr_o !== 7'd0) begin failures++; $display("FAIL rst_wrif_addr actual=%0d expected=0", wrif_addr_o); end
    checks++; if (wrif_data_o !== '0) begin failures++; $display("FAIL rst_wrif_data actual=%h expected=0", wrif_data_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b expected=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done actual=%b expected=0", done_o); end
  endtask

  task automatic test_basic();
    clear_log();
    do_start(0, 2);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy actual=%b expected=1", busy_o); end
    send_beats(0, 6, 0);
    checks++; if (wrif_en_o !== 1'b1) begin failures++; $display("FAIL basic_write_latency wrif_en actual=%b expected=1", wrif_en_o); end
    checks++; if (wrif_data_o !== row_exp(0)) begin failures++; $display("FAIL basic_row0_data actual=%h expected=%h", wrif_data_o, row_exp(0)); end
    send_beats(6, 6, 0);
    wait_done(20);
    chk_int("basic_write_count", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      chk_int("basic_addr0", wq_addr[0], 0);
      chk_int("basic_addr1", wq_addr[1], 1);
      checks++; if (wq_data[1] !== row_exp(6)) begin failures++; $display("FAIL basic_row1_data actual=%h expected=%h", wq_data[1], row_exp(6)); end
    end
    chk_int("basic_done_count", done_cnt, 1);
    chk_int("basic_hold_addr", wrif_addr_o, 1);
    checks++; if (wrif_data_o !== row_exp(6)) begin failures++; $display("FAIL basic_hold_data actual=%h expected=%h", wrif_data_o, row_exp(6)); end
    chk_int("basic_idle_busy", busy_o, 0);
  endtask

  task automatic test_wrap();
    clear_log();
    do_start(95, 3);
    send_beats(0, 18, 0);
    wait_done(20);
    chk_int("wrap_write_count", wq_addr.size(), 3);
    if (wq_addr.size() == 3) begin
      chk_int("wrap_addr0", wq_addr[0], 95);
      chk_int("wrap_addr1", wq_addr[1], 0);
      chk_int("wrap_addr2", wq_addr[2], 1);
    end
    clear_log();
    do_start(100, 1);
    send_beats(30, 6, 0);
    wait_done(20);
    chk_int("base_mod_count", wq_addr.size(), 1);
    if (wq_addr.size() == 1) chk_int("base_mod_addr", wq_addr[0], 4);
  endtask

  task automatic test_zero_rows();
    clear_log();
    in_valid_i = 1;
    in_data_i  = beat(77);
    do_start(10, 0);
    chk_int("zero_done_pulse", done_o, 1);
    chk_int("zero_busy", busy_o, 0);
    step();
    chk_int("zero_done_cleared", done_o, 0);
    repeat (3) step();
    in_valid_i = 0;
    chk_int("zero_write_count", wq_addr.size(), 0);
    chk_int("zero_ready_seen", ready_seen, 0);
    chk_int("zero_done_count", done_cnt, 1);
  endtask

  task automatic test_gaps();
    clear_log();
    do_start(10, 2);
    send_beats(0, 3, 1);
    do_start(50, 5);
    send_beats(3, 9, 1);
    wait_done(40);
    repeat (8) step();
    chk_int("gaps_write_count", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      chk_int("gaps_addr0", wq_addr[0], 10);
      chk_int("gaps_addr1", wq_addr[1], 11);
      checks++; if (wq_data[0] !== row_exp(0)) begin failures++; $display("FAIL gaps_row0_data actual=%h expected=%h", wq_data[0], row_exp(0)); end
      checks++; if (wq_data[1] !== row_exp(6)) begin failures++; $display("FAIL gaps_row1_data actual=%h expected=%h", wq_data[1], row_exp(6)); end
    end
    chk_int("gaps_done_count", done_cnt, 1);
    chk_int("gaps_idle_after", busy_o, 0);
  endtask

  task automatic test_mid_reset();
    clear_log();
    do_start(5, 2);
    send_beats(40, 3, 0);
    rst = 1;
    step();
    rst = 0;
    chk_int("midrst_in_ready", in_ready_o, 0);
    chk_int("midrst_wrif_en", wrif_en_o, 0);
    chk_int("midrst_wrif_addr", wrif_addr_o, 0);
    checks++; if (wrif_data_o !== '0) begin failures++; $display("FAIL midrst_wrif_data actual=%h expected=0", wrif_data_o); end
    chk_int("midrst_busy", busy_o, 0);
    repeat (10) step();
    chk_int("midrst_no_write", wq_addr.size(), 0);
    chk_int("midrst_no_done", done_cnt, 0);
    // reset wins over a simultaneous start
    rst = 1;
    do_start(20, 4);
    rst = 0;
    chk_int("rst_vs_start_busy", busy_o, 0);
    step();
    chk_int("rst_vs_start_busy2", busy_o, 0);
    chk_int("rst_vs_start_done", done_cnt, 0);
    do_start(7, 1);
    send_beats(20, 6, 0);
    wait_done(20);
    chk_int("midrst_fresh_count", wq_addr.size(), 1);
    if (wq_addr.size() == 1) begin
      chk_int("midrst_fresh_addr", wq_addr[0], 7);
      checks++; if (wq_data[0] !== row_exp(20)) begin failures++; $display("FAIL midrst_fresh_data actual=%h expected=%h", wq_data[0], row_exp(20)); end
    end
  endtask

  task automatic test_clamp();
    bit seen[DEPTH];
    int order_err = 0, dup_err = 0;
    clear_log();
    for (int i = 0; i < DEPTH; i++) seen[i] = 0;
    do_start(40, 100);
    send_beats(0, DEPTH * RB, 0);
    wait_done(20);
    chk_int("clamp_write_count", wq_addr.size(), DEPTH);
    foreach (wq_addr[i]) begin
      if (wq_addr[i] !== 7'((40 + i) % DEPTH)) order_err++;
      if (seen[wq_addr[i] % DEPTH]) dup_err++;
      seen[wq_addr[i] % DEPTH] = 1;
    end
    chk_int("clamp_addr_order_errors", order_err, 0);
    chk_int("clamp_addr_dup_errors", dup_err, 0);
    chk_int("clamp_done_count", done_cnt, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_rows();
    test_gaps();
    test_mid_reset();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
